reg_file: RTL and testbench

Eight-entry, 8-bit register file with a shift-carry register and a zero-flag register. It sits on both sides of the ALU:
- Two combinational read ports drive the ALU InputA/InputB.
- The shift-carry register drives ALU SC_in.
- The write port captures ALU Out at the end of the execute cycle.
- The flag register captures ALU Zero for the branch logic.

It is the only architectural state besides the PC.

---
 rtl/reg_file_pkg.sv | 8 +
 rtl/reg_file_if.sv | 25 ++
 rtl/reg_file_flag_reg.sv | 12 +
 rtl/reg_file.sv | 36 +++
 tb/tb_reg_file.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and types for the register file and its decoder.
package reg_file_pkg;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NUM_REGS = 2 ** AW;
    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: ALU-side bus of the register file; master drives addresses/writes, slave returns data and flags.
interface reg_file_if;
    import reg_file_pkg::*;
    reg_addr_t raddr_a;
    reg_addr_t raddr_b;
    reg_data_t data_out_a;
    reg_data_t data_out_b;
    logic      write_en;
    reg_addr_t waddr;
    reg_data_t data_in;
    logic      sc_we;
    logic      sc_in;
    logic      sc_out;
    logic      flag_we;
    logic      zero_in;
    logic      zero_out;
    modport master (
        output raddr_a, raddr_b, write_en, waddr, data_in, sc_we, sc_in, flag_we, zero_in,
        input  data_out_a, data_out_b, sc_out, zero_out
    );
    modport slave (
        input  raddr_a, raddr_b, write_en, waddr, data_in, sc_we, sc_in, flag_we, zero_in,
        output data_out_a, data_out_b, sc_out, zero_out
    );
endinterface

// File: rtl/reg_file_flag_reg.sv
// flag_reg: 1-bit enable-gated flop with synchronous active-high reset.
module flag_reg (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk)
        if (rst) q <= 1'b0;
        else if (en) q <= d;
endmodule

// File: rtl/reg_file.sv
// reg_file: 8x8 register file with shift-carry and zero-flag registers, two async read ports.
// REGFILE_BYPASS_EN: write-first forwarding of data_in onto a read port whose address matches waddr.
module reg_file
    import reg_file_pkg::*;
(
    input  logic clk,
    input  logic reset,
    reg_file_if.slave bus
);
    reg_data_t mem [NUM_REGS];
    always_ff @(posedge clk)
        if (reset) mem <= '{default: '0};
        else if (bus.write_en) mem[bus.waddr] <= bus.data_in;
`ifdef REGFILE_BYPASS_EN
    // forwarding ignores reset so the read path stays a pure function of the write port
    assign bus.data_out_a = (bus.write_en && bus.raddr_a == bus.waddr) ? bus.data_in : mem[bus.raddr_a];
    assign bus.data_out_b = (bus.write_en && bus.raddr_b == bus.waddr) ? bus.data_in : mem[bus.raddr_b];
`else
    assign bus.data_out_a = mem[bus.raddr_a];
    assign bus.data_out_b = mem[bus.raddr_b];
`endif
    flag_reg u_sc (
        .clk(clk),
        .rst(reset),
        .en (bus.sc_we),
        .d  (bus.sc_in),
        .q  (bus.sc_out)
    );
    flag_reg u_zero (
        .clk(clk),
        .rst(reset),
        .en (bus.flag_we),
        .d  (bus.zero_in),
        .q  (bus.zero_out)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
module tb_reg_file;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    reg_file_if bus ();
    reg_file dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        reset = 1'b0;
        bus.write_en = 1'b0;
        bus.sc_we = 1'b0;
        bus.flag_we = 1'b0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        bus.write_en = 1'b1;
        bus.waddr = a;
        bus.data_in = d;
        tick();
        bus.write_en = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
        bus.raddr_a = a;
        bus.raddr_b = a;
        #1;
        checks += 2;
        if (bus.data_out_a !== exp) begin
            errors++;
            $display("FAIL %s port A r%0d: got %h expected %h", name, a, bus.data_out_a, exp);
        end
        if (bus.data_out_b !== exp) begin
            errors++;
            $display("FAIL %s port B r%0d: got %h expected %h", name, a, bus.data_out_b, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.write_en = 1'b1;
        bus.waddr = 3'd4;
        bus.data_in = 8'hFF;
        bus.sc_we = 1'b1;
        bus.sc_in = 1'b1;
        bus.flag_we = 1'b1;
        bus.zero_in = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 8; i++) check_reg("reset", 3'(i), 8'h00);
        checks += 2;
        if (bus.sc_out !== 1'b0) begin
            errors++;
            $display("FAIL reset sc_out: got %b expected 0", bus.sc_out);
        end
        if (bus.zero_out !== 1'b0) begin
            errors++;
            $display("FAIL reset zero_out: got %b expected 0", bus.zero_out);
        end
    endtask

    task automatic test_read_write;
        write_reg(3'd3, 8'h5A);
        write_reg(3'd5, 8'hC3);
        bus.raddr_a = 3'd3;
        bus.raddr_b = 3'd5;
        #1;
        checks += 2;
        if (bus.data_out_a !== 8'h5A) begin
            errors++;
            $display("FAIL rw port A: got %h expected 5a", bus.data_out_a);
        end
        if (bus.data_out_b !== 8'hC3) begin
            errors++;
            $display("FAIL rw port B: got %h expected c3", bus.data_out_b);
        end
        check_reg("rw same addr", 3'd3, 8'h5A);
        check_reg("rw untouched", 3'd4, 8'h00);
    endtask

    task automatic test_bypass;
        logic [7:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 8'h22;
`else
        exp_pre = 8'h11;
`endif
        write_reg(3'd2, 8'h11);
        bus.write_en = 1'b1;
        bus.waddr = 3'd2;
        bus.data_in = 8'h22;
        bus.raddr_a = 3'd2;
        bus.raddr_b = 3'd5;
        #1;
        checks += 2;
        if (bus.data_out_a !== exp_pre) begin
            errors++;
            $display("FAIL bypass pre-edge: got %h expected %h", bus.data_out_a, exp_pre);
        end
        if (bus.data_out_b !== 8'hC3) begin
            errors++;
            $display("FAIL bypass other port: got %h expected c3", bus.data_out_b);
        end
        tick();
        bus.write_en = 1'b0;
        check_reg("bypass post-edge", 3'd2, 8'h22);
    endtask

    task automatic test_flags;
        bus.sc_we = 1'b1;
        bus.sc_in = 1'b1;
        tick();
        bus.sc_we = 1'b0;
        bus.sc_in = 1'b0;
        checks++;
        if (bus.sc_out !== 1'b1) begin
            errors++;
            $display("FAIL sc set: got %b expected 1", bus.sc_out);
        end
        tick();
        checks++;
        if (bus.sc_out !== 1'b1) begin
            errors++;
            $display("FAIL sc hold: got %b expected 1", bus.sc_out);
        end
        bus.flag_we = 1'b1;
        bus.zero_in = 1'b1;
        write_reg(3'd6, 8'h77);
        bus.flag_we = 1'b0;
        bus.zero_in = 1'b0;
        checks++;
        if (bus.zero_out !== 1'b1) begin
            errors++;
            $display("FAIL zero set: got %b expected 1", bus.zero_out);
        end
        check_reg("write with flag", 3'd6, 8'h77);
        tick();
        checks += 2;
        if (bus.zero_out !== 1'b1) begin
            errors++;
            $display("FAIL zero hold: got %b expected 1", bus.zero_out);
        end
        if (bus.sc_out !== 1'b1) begin
            errors++;
            $display("FAIL sc unaffected by flag: got %b expected 1", bus.sc_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] sum;
        write_reg(3'd1, 8'h01);
        check_reg("loop start", 3'd1, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            bus.raddr_a = 3'd1;
            bus.raddr_b = 3'd1;
            #1;
            sum = bus.data_out_a + bus.data_out_b;
            write_reg(3'd1, sum);
            check_reg("loop add", 3'd1, 8'(1 << i));
        end
    endtask

    task automatic test_reset_discard;
        write_reg(3'd7, 8'hAA);
        check_reg("r7 before reset", 3'd7, 8'hAA);
        reset = 1'b1;
        bus.write_en = 1'b1;
        bus.waddr = 3'd7;
        bus.data_in = 8'h55;
        tick();
        idle();
        check_reg("reset discards write", 3'd7, 8'h00);
        check_reg("reset clears r1", 3'd1, 8'h00);
        checks++;
        if (bus.sc_out !== 1'b0) begin
            errors++;
            $display("FAIL reset clears sc: got %b expected 0", bus.sc_out);
        end
    endtask

    initial begin
        idle();
        bus.raddr_a = '0;
        bus.raddr_b = '0;
        bus.waddr = '0;
        bus.data_in = '0;
        bus.sc_in = 1'b0;
        bus.zero_in = 1'b0;
        tick();
        test_reset();
        test_read_write();
        test_bypass();
        test_flags();
        test_back_to_back();
        test_reset_discard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
